// File: rtl/rv_reg_file.sv
// rv_reg_file: 32 x XLEN integer register file for the single-cycle RISC-V datapath.
// Two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN: write-through forwarding from WD3 to the read ports.
module rv_reg_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            WE3,
    input  logic [AW-1:0]   RA1,
    input  logic [AW-1:0]   RA2,
    input  logic [AW-1:0]   WA3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    // x0 is never written, so it stays at its reset value of zero
    assign wr_en = WE3 && (WA3 != '0);

    // Storage: async clear on reset, single write per rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WA3] <= WD3;
        end
    end

    // Read ports: x0 and reset force zero; optional forwarding of the in-flight write
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (!reset) begin
            if (RA1 != '0) RD1 = regs_q[RA1];
            if (RA2 != '0) RD2 = regs_q[RA2];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (RA1 == WA3)) RD1 = WD3;
            if (wr_en && (RA2 == WA3)) RD2 = WD3;
`endif
        end
    end

endmodule

// File: tb/tb_rv_reg_file.sv
// Self-checking bench for rv_reg_file: directed test-plan cases plus random traffic
// compared against an array-based reference model of the architectural registers.
module tb_rv_reg_file;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            WE3;
    logic [4:0]      RA1;
    logic [4:0]      RA2;
    logic [4:0]      WA3;
    logic [XLEN-1:0] WD3;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;

    int n_vec;
    int n_err;
    logic [XLEN-1:0] mdl [32];

    rv_reg_file #(
        .XLEN (XLEN),
        .NREGS(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .WE3  (WE3),
        .RA1  (RA1),
        .RA2  (RA2),
        .WA3  (WA3),
        .WD3  (WD3),
        .RD1  (RD1),
        .RD2  (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Architectural view of a read given the current (pre-edge) inputs
    function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] ra);
        if (reset) return '0;
`ifdef REGFILE_BYPASS_EN
        if (WE3 && WA3 != 5'd0 && ra == WA3) return WD3;
`endif
        if (ra == 5'd0) return '0;
        return mdl[ra];
    endfunction

    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, RD1, exp_rd(RA1));
        check({tag, "_rd2"}, RD2, exp_rd(RA2));
    endtask

    // Apply one rising edge and track its effect in the model
    task automatic step();
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else if (WE3 && WA3 != 5'd0) begin
            mdl[WA3] = WD3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_model();
        WE3   = 1'b0;
        WA3   = '0;
        WD3   = '0;
        RA1   = 5'd1;
        RA2   = 5'd2;

        // Reset then read
        reset = 1'b1;
        #2;
        check("rst_rd1", RD1, '0);
        check("rst_rd2", RD2, '0);
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(31 - i);
            #1;
            check("post_rst_rd1", RD1, '0);
            check("post_rst_rd2", RD2, '0);
        end

        // Write disabled
        WE3 = 1'b0; WA3 = 5'd1; WD3 = 32'h12345678; RA1 = 5'd1; RA2 = 5'd2;
        step();
        check("we0_rd1", RD1, '0);
        check("we0_rd2", RD2, '0);

        // Write enabled: pre-edge value depends on forwarding
        WE3 = 1'b1; WA3 = 5'd1; WD3 = 32'h12345678; RA1 = 5'd1; RA2 = 5'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("we1_pre_rd1", RD1, 32'h12345678);
`else
        check("we1_pre_rd1", RD1, '0);
`endif
        step();
        WE3 = 1'b0;
        #1;
        check("we1_post_rd1", RD1, 32'h12345678);
        check("we1_post_rd2", RD2, '0);

        // x0 protection
        WE3 = 1'b1; WA3 = 5'd0; WD3 = 32'hFFFFFFFF; RA1 = 5'd0; RA2 = 5'd0;
        #1;
        check("x0_pre_rd1", RD1, '0);
        step();
        WE3 = 1'b0;
        #1;
        check("x0_rd1", RD1, '0);
        check("x0_rd2", RD2, '0);

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            WE3 = 1'b1; WA3 = 5'(i); WD3 = 32'hA5A50000 + 32'(i);
            step();
        end
        WE3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(i);
            #1;
            check("sweep_rd1", RD1, (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i));
            check("sweep_rd2", RD2, (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i));
        end

        // Async reset mid-operation
        WE3 = 1'b1; WA3 = 5'd5; WD3 = 32'd7; RA1 = 5'd5; RA2 = 5'd31;
        step();
        check("mid_wr_rd1", RD1, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rd1", RD1, '0);
        check("mid_rst_rd2", RD2, '0);
        step();
        reset = 1'b0;
        WE3 = 1'b0;
        #1;
        check("mid_hold_rd1", RD1, '0);
        check("mid_hold_rd2", RD2, '0);
        // First edge after deassertion accepts a write
        WE3 = 1'b1; WA3 = 5'd5; WD3 = 32'hCAFEF00D;
        step();
        WE3 = 1'b0;
        #1;
        check("mid_first_wr", RD1, 32'hCAFEF00D);

        // Random traffic, concentrated on a few addresses to exercise collisions
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            WE3   = 1'($urandom_range(0, 3) != 0);
            WA3   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            WD3   = $urandom;
            RA1   = ($urandom_range(0, 2) == 0) ? WA3 : 5'($urandom_range(0, 7));
            RA2   = ($urandom_range(0, 2) == 0) ? RA1 : 5'($urandom);
            #1;
            check_ports("rnd_pre");
            step();
            reset = 1'b0;
            WE3   = 1'b0;
            #1;
            check_ports("rnd_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
